// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobe, 2-FF column sync, frame debounce,
// ghost rejection and a small key-code FIFO with sticky overflow.
module keypad_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_o,
    input  logic [3:0] col_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    input  logic       key_ready_i,
    output logic       key_pressed_o,
    output logic       overflow_o,
    input  logic       clr_ovf_i
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        ST_BOUNCE,
        ST_STABLE
    } state_t;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [DW-1:0] r_div;
    logic [1:0]    r_row;
    logic [15:0]   r_snap;
    logic          r_fe;
    logic [15:0]   r_prev;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic [15:0]   r_deb;
    logic          r_pressed;
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_ovf;

    logic          w_tick;
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cand;
    logic          w_multi;
    logic          w_accept;
    logic          w_event;
    logic [3:0]    w_code;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Columns are inverted on entry so that 1 means pressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~col_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_div == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_row <= 2'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_row <= r_row + 2'd1;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign row_o = ~(4'b0001 << r_row);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap <= '0;
            r_fe   <= 1'b0;
        end else begin
            r_fe <= w_tick && (r_row == 2'd3);
            if (w_tick) begin
                r_snap[{r_row, 2'b00} +: 4] <= r_sync2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BOUNCE;
            r_cnt   <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_fe) begin
                r_prev <= r_snap;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_fe) begin
            if (r_snap != r_prev) begin
                w_state_nxt = ST_BOUNCE;
                w_cnt_nxt   = '0;
            end else begin
                if (r_cnt != CW'(DEBOUNCE_CNT)) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
                if ((r_state == ST_BOUNCE) &&
                    (w_cnt_nxt == CW'(DEBOUNCE_CNT))) begin
                    w_state_nxt = ST_STABLE;
                end
            end
        end
    end

    // A frame becomes a candidate only on the BOUNCE->STABLE transition.
    always_comb begin
        w_cand   = (r_state == ST_BOUNCE) && (w_state_nxt == ST_STABLE);
        w_multi  = |(r_snap & (r_snap - 16'd1));
        w_accept = w_cand && !w_multi;
        w_event  = w_accept && |(r_snap & ~r_deb);
        w_code   = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_snap[i]) begin
                w_code = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deb     <= '0;
            r_pressed <= 1'b0;
        end else begin
            r_pressed <= |r_deb;
            if (w_accept) begin
                r_deb <= r_snap;
            end
        end
    end

    assign key_pressed_o = r_pressed;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && key_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= w_code;
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    assign key_valid_o = !w_empty;
    assign key_code_o  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: emulated key matrix, frame-level reference model,
// directed scenarios with literal expectations, then random stimulus.
module tb_keypad_scan;

    localparam int S  = 4;
    localparam int DC = 2;
    localparam int D  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_o;
    logic [3:0] col_i;
    logic       key_valid_o;
    logic [3:0] key_code_o;
    logic       key_ready_i = 1'b0;
    logic       key_pressed_o;
    logic       overflow_o;
    logic       clr_ovf_i = 1'b0;
    logic [15:0] keys = 16'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV(S),
        .DEBOUNCE_CNT(DC),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_o(row_o),
        .col_i(col_i),
        .key_valid_o(key_valid_o),
        .key_code_o(key_code_o),
        .key_ready_i(key_ready_i),
        .key_pressed_o(key_pressed_o),
        .overflow_o(overflow_o),
        .clr_ovf_i(clr_ovf_i)
    );

    // Matrix: a closed key pulls its column low while its row is driven low.
    function automatic logic [3:0] sense(input logic [15:0] k,
                                         input logic [3:0] r);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 0; i < 4; i++)
            if (!r[i]) c = c | k[4*i +: 4];
        return ~c;
    endfunction

    assign col_i = sense(keys, row_o);

    // Reference model state
    bit          m_live = 0;
    int          m_t;
    logic [3:0]  m_s1, m_s2;
    logic [15:0] m_snap, m_prev, m_deb;
    logic        m_fe, m_pressed, m_ovf;
    int          m_run;
    logic [3:0]  q[$];
    logic [3:0]  m_code;
    bit          m_ev, m_pop, m_drop, m_tick;
    int          m_row;

    // Would the frame now awaiting evaluation produce a press event?
    function automatic bit m_event(output logic [3:0] code);
        code = 4'h0;
        if (!m_fe || m_snap != m_prev || m_run + 1 != DC) return 0;
        if ($countones(m_snap) != 1) return 0;
        if ((m_snap & ~m_deb) == 16'h0) return 0;
        for (int i = 0; i < 16; i++)
            if (m_snap[i]) code = 4'(i);
        return 1;
    endfunction

    always @(posedge clk) begin
        m_live = 1;
        if (!rst_n) begin
            m_t = 0;
            m_s1 = 0; m_s2 = 0;
            m_snap = 0; m_prev = 0; m_deb = 0;
            m_fe = 0; m_pressed = 0; m_ovf = 0;
            m_run = 0;
            q.delete();
        end else begin
            m_ev = m_event(m_code);
            m_pressed = |m_deb;
            if (m_fe) begin
                if (m_snap == m_prev) begin
                    m_run++;
                    if (m_run == DC && $countones(m_snap) <= 1)
                        m_deb = m_snap;
                end else begin
                    m_run = 0;
                end
                m_prev = m_snap;
            end
            m_tick = (m_t % S) == S - 1;
            m_row = (m_t / S) % 4;
            m_fe = m_tick && m_row == 3;
            if (m_tick) m_snap[4*m_row +: 4] = m_s2;
            m_s2 = m_s1;
            m_s1 = ~col_i;
            m_pop = q.size() > 0 && key_ready_i;
            m_drop = m_ev && q.size() == D && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_ev && !m_drop) q.push_back(m_code);
            if (m_drop) m_ovf = 1;
            else if (clr_ovf_i) m_ovf = 0;
            m_t++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    logic [3:0] exp_row;

    always @(negedge clk) begin
        if (m_live) begin
            exp_row = ~(4'b0001 << ((m_t / S) % 4));
            chk("row", row_o, exp_row);
            chk("valid", key_valid_o, q.size() > 0);
            if (q.size() > 0) chk("code", key_code_o, q[0]);
            chk("pressed", key_pressed_o, m_pressed);
            chk("ovf", overflow_o, m_ovf);
        end
    end

    task automatic frames(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    task automatic pop1();
        key_ready_i = 1'b1;
        @(negedge clk);
        key_ready_i = 1'b0;
    endtask

    task automatic tap(input int c);
        keys = 16'h1 << c;
        frames(5);
        keys = 16'h0;
        frames(5);
    endtask

    logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] dc;
    bit found;
    int rr, hold, b1, b2, slow;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_row", row_o, 4'b1110);
        chk("rst_valid", key_valid_o, 0);
        chk("rst_code", key_code_o, 0);
        chk("rst_pressed", key_pressed_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            chk("rotation", row_o, rot[(k / 4) % 4]);
            @(negedge clk);
        end

        // Single press of row 2 / col 1
        keys = 16'h0200;
        frames(5);
        chk("press_valid", key_valid_o, 1);
        chk("press_code", key_code_o, 4'h9);
        chk("press_held", key_pressed_o, 1);
        chk("model_one_entry", q.size(), 1);
        pop1();
        chk("press_single", key_valid_o, 0);
        keys = 16'h0;
        frames(5);
        chk("release_pressed", key_pressed_o, 0);
        chk("release_no_entry", key_valid_o, 0);

        // Bounce then hold
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            frames(1);
        end
        chk("bounce_no_entry", key_valid_o, 0);
        keys = 16'h0200;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (key_valid_o) found = 1;
        end
        chk("bounce_found", found, 1);
        chk("bounce_code", key_code_o, 4'h9);
        pop1();
        keys = 16'h0;
        frames(5);

        // Ghost: keys 0 and 5 together, then release 5
        keys = 16'h0021;
        frames(5);
        chk("ghost_no_entry", key_valid_o, 0);
        chk("ghost_pressed", key_pressed_o, 0);
        keys = 16'h0001;
        frames(5);
        chk("ghost_valid", key_valid_o, 1);
        chk("ghost_code", key_code_o, 4'h0);
        chk("model_ghost_code", q[0], 0);
        pop1();
        keys = 16'h0;
        frames(5);

        // Overflow with consumer stalled
        for (int c = 1; c <= 5; c++) tap(c);
        chk("ovf_set", overflow_o, 1);
        chk("model_ovf_depth", q.size(), 4);
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
        chk("ovf_clr", overflow_o, 0);
        for (int c = 1; c <= 4; c++) begin
            chk("ovf_entry", key_code_o, c);
            pop1();
        end
        chk("ovf_drained", key_valid_o, 0);

        // Full FIFO, push and pop in the same cycle
        for (int c = 1; c <= 4; c++) tap(c);
        keys = 16'h0040;
        found = 0;
        for (int i = 0; i < 96 && !found; i++) begin
            @(negedge clk);
            if (m_event(dc)) begin
                key_ready_i = 1'b1;
                @(negedge clk);
                key_ready_i = 1'b0;
                found = 1;
            end
        end
        chk("pp_event_seen", found, 1);
        chk("pp_no_ovf", overflow_o, 0);
        chk("model_pp_depth", q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("pp_entry", key_code_o, (i == 3) ? 6 : i + 2);
            pop1();
        end
        keys = 16'h0;
        frames(5);

        // Reset mid-frame with live state
        keys = 16'h0008;
        frames(5);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_row", row_o, 4'b1110);
        chk("mid_rst_valid", key_valid_o, 0);
        chk("mid_rst_code", key_code_o, 0);
        chk("mid_rst_pressed", key_pressed_o, 0);
        chk("mid_rst_ovf", overflow_o, 0);
        rst_n = 1'b1;

        // Random keys, consumer and overflow clears
        for (int n = 0; n < 150; n++) begin
            rr = $urandom_range(0, 9);
            b1 = $urandom_range(0, 15);
            b2 = $urandom_range(0, 15);
            if (rr < 4) keys = 16'h0;
            else if (rr < 8) keys = 16'h1 << b1;
            else keys = (16'h1 << b1) | (16'h1 << b2);
            hold = $urandom_range(1, 90);
            slow = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int c = 0; c < hold; c++) begin
                key_ready_i = slow && ($urandom_range(0, 2) == 0);
                clr_ovf_i = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        key_ready_i = 1'b0;
        clr_ovf_i = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
